// File: rtl/rf_wport_arb_pkg.sv
// Shared defines for the register-file write-port arbiter: widths and holding-buffer states.
package rf_wport_arb_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned XLEN  = 32;

    typedef enum logic [0:0] {
        StEmpty = 1'b0,
        StHeld  = 1'b1
    } hold_state_e;

endpackage

// File: rtl/rf_wport_hold.sv
// One-entry holding buffer for a deferred MDU result, with a saturating wait counter.
module rf_wport_hold
    import rf_wport_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture,
    input  logic [REG_W-1:0] cap_rd,
    input  logic [XLEN-1:0]  cap_data,
    input  logic             drain,
    input  logic             inc,
    output logic             valid,
    output logic [REG_W-1:0] rd,
    output logic [XLEN-1:0]  data,
    output logic [7:0]       wait_cnt
);

    localparam logic [7:0] StarveMaxW = 8'(STARVE_MAX);

    hold_state_e      state_q;
    logic [REG_W-1:0] rd_q;
    logic [XLEN-1:0]  data_q;
    logic [7:0]       cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            rd_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else if (capture) begin
            state_q <= StHeld;
            rd_q    <= cap_rd;
            data_q  <= cap_data;
            cnt_q   <= '0;
        end else if (drain) begin
            state_q <= StEmpty;
            rd_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else if (inc && (cnt_q < StarveMaxW)) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign valid    = (state_q == StHeld);
    assign rd       = rd_q;
    assign data     = data_q;
    assign wait_cnt = cnt_q;

endmodule

// File: rtl/rf_wport_arb.sv
// Arbitrates the single register-file write port between pipeline writeback and the MDU,
// deferring an MDU result into a one-entry buffer and forcing it out after STARVE_MAX waits.
module rf_wport_arb
    import rf_wport_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_we,
    input  logic [REG_W-1:0] wb_rd,
    input  logic [XLEN-1:0]  wb_wD,
    output logic             wb_stall,
    input  logic             mdu_valid,
    input  logic [REG_W-1:0] mdu_rd,
    input  logic [XLEN-1:0]  mdu_result,
    output logic             mdu_ready,
    output logic             rf_we,
    output logic [REG_W-1:0] rf_wR,
    output logic [XLEN-1:0]  rf_wD,
    output logic             mdu_pend,
    output logic [REG_W-1:0] mdu_pend_rd
);

    localparam logic [7:0] StarveMaxW = 8'(STARVE_MAX);

    logic             buf_valid;
    logic [REG_W-1:0] buf_rd;
    logic [XLEN-1:0]  buf_data;
    logic [7:0]       wait_cnt;
    logic             capture, drain, inc;
    logic             pipe_req, mdu_live;

    // x0 writes from either source are consumed without touching the port.
    assign pipe_req  = wb_we && (wb_rd != '0);
    assign mdu_ready = rst_n && !buf_valid;
    assign mdu_live  = mdu_valid && mdu_ready && (mdu_rd != '0);

    always_comb begin
        rf_we    = 1'b0;
        rf_wR    = '0;
        rf_wD    = '0;
        wb_stall = 1'b0;
        capture  = 1'b0;
        drain    = 1'b0;
        inc      = 1'b0;
        if (rst_n) begin
            if (buf_valid) begin
                if (pipe_req && (wait_cnt < StarveMaxW)) begin
                    rf_we = 1'b1;
                    rf_wR = wb_rd;
                    rf_wD = wb_wD;
                    inc   = 1'b1;
                end else begin
                    // Either the port is free or the wait bound has been reached.
                    rf_we    = 1'b1;
                    rf_wR    = buf_rd;
                    rf_wD    = buf_data;
                    wb_stall = pipe_req;
                    drain    = 1'b1;
                end
            end else if (pipe_req) begin
                rf_we   = 1'b1;
                rf_wR   = wb_rd;
                rf_wD   = wb_wD;
                capture = mdu_live;
            end else if (mdu_live) begin
                rf_we = 1'b1;
                rf_wR = mdu_rd;
                rf_wD = mdu_result;
            end
        end
    end

    rf_wport_hold #(
        .STARVE_MAX (STARVE_MAX)
    ) u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .capture  (capture),
        .cap_rd   (mdu_rd),
        .cap_data (mdu_result),
        .drain    (drain),
        .inc      (inc),
        .valid    (buf_valid),
        .rd       (buf_rd),
        .data     (buf_data),
        .wait_cnt (wait_cnt)
    );

    assign mdu_pend    = rst_n && buf_valid;
    assign mdu_pend_rd = mdu_pend ? buf_rd : '0;

endmodule

// File: tb/tb_rf_wport_arb.sv
// Directed bench for rf_wport_arb: bypass, deferral, forced drain, x0 handling and reset.
module tb_rf_wport_arb;

    logic        clk;
    logic        rst_n;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wD;
    logic        wb_stall;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_result;
    logic        mdu_ready;
    logic        rf_we;
    logic [4:0]  rf_wR;
    logic [31:0] rf_wD;
    logic        mdu_pend;
    logic [4:0]  mdu_pend_rd;

    int total = 0;
    int bad   = 0;

    rf_wport_arb #(
        .STARVE_MAX (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_wD       (wb_wD),
        .wb_stall    (wb_stall),
        .mdu_valid   (mdu_valid),
        .mdu_rd      (mdu_rd),
        .mdu_result  (mdu_result),
        .mdu_ready   (mdu_ready),
        .rf_we       (rf_we),
        .rf_wR       (rf_wR),
        .rf_wD       (rf_wD),
        .mdu_pend    (mdu_pend),
        .mdu_pend_rd (mdu_pend_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] mres);
        wb_we      = we;
        wb_rd      = rd;
        wb_wD      = wd;
        mdu_valid  = mv;
        mdu_rd     = mrd;
        mdu_result = mres;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic port(input string tag, input logic we, input logic [4:0] wr,
                        input logic [31:0] wd, input logic stall);
        check({tag, ".rf_we"}, 32'(rf_we), 32'(we));
        check({tag, ".rf_wR"}, 32'(rf_wR), 32'(wr));
        check({tag, ".rf_wD"}, rf_wD, wd);
        check({tag, ".wb_stall"}, 32'(wb_stall), 32'(stall));
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2);
        port("rst", 1'b0, 5'd0, 32'h0, 1'b0);
        check("rst.mdu_ready", 32'(mdu_ready), 32'h0);
        check("rst.mdu_pend", 32'(mdu_pend), 32'h0);
        tick();
        rst_n = 1'b1;

        // MDU bypass into an empty port
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF);
        port("byp", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        check("byp.mdu_ready", 32'(mdu_ready), 32'h1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        port("byp_idle", 1'b0, 5'd0, 32'h0, 1'b0);
        check("byp_idle.mdu_pend", 32'(mdu_pend), 32'h0);
        tick();

        // Collision: pipeline wins, MDU result deferred then drained on a free cycle
        drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
        port("col", 1'b1, 5'd3, 32'h11, 1'b0);
        check("col.mdu_ready", 32'(mdu_ready), 32'h1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("col.mdu_pend", 32'(mdu_pend), 32'h1);
        check("col.mdu_pend_rd", 32'(mdu_pend_rd), 32'h7);
        check("col.mdu_ready_held", 32'(mdu_ready), 32'h0);
        port("drain", 1'b1, 5'd7, 32'h22, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("drain.mdu_pend", 32'(mdu_pend), 32'h0);
        check("drain.mdu_pend_rd", 32'(mdu_pend_rd), 32'h0);
        check("drain.mdu_ready", 32'(mdu_ready), 32'h1);
        port("drain_idle", 1'b0, 5'd0, 32'h0, 1'b0);
        tick();

        // Starvation bound: 4 pipeline writes, then forced drain with stall
        drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd9, 32'h99);
        port("cap9", 1'b1, 5'd1, 32'h100, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'(10 + i), 32'(32'h200 + i), 1'b0, 5'd0, 32'h0);
            port($sformatf("starve%0d", i), 1'b1, 5'(10 + i), 32'(32'h200 + i), 1'b0);
            check($sformatf("starve%0d.mdu_ready", i), 32'(mdu_ready), 32'h0);
            tick();
        end
        drive(1'b1, 5'd14, 32'h204, 1'b0, 5'd0, 32'h0);
        port("force", 1'b1, 5'd9, 32'h99, 1'b1);
        tick();
        drive(1'b1, 5'd14, 32'h204, 1'b0, 5'd0, 32'h0);
        port("replay", 1'b1, 5'd14, 32'h204, 1'b0);
        check("replay.mdu_ready", 32'(mdu_ready), 32'h1);
        check("replay.mdu_pend", 32'(mdu_pend), 32'h0);
        tick();

        // Pipeline write to x0 while held does not count as a request
        drive(1'b1, 5'd2, 32'h300, 1'b1, 5'd12, 32'hC);
        tick();
        drive(1'b1, 5'd0, 32'h301, 1'b0, 5'd0, 32'h0);
        port("x0drain", 1'b1, 5'd12, 32'hC, 1'b0);
        tick();

        // MDU rd=0 consumed alongside a pipeline write, and alone
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd0, 32'h55);
        port("mdu_x0", 1'b1, 5'd4, 32'h44, 1'b0);
        check("mdu_x0.mdu_ready", 32'(mdu_ready), 32'h1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h66);
        port("mdu_x0_solo", 1'b0, 5'd0, 32'h0, 1'b0);
        check("mdu_x0.mdu_pend", 32'(mdu_pend), 32'h0);
        tick();

        // Reset while held with wait_cnt=2 discards the buffered result
        drive(1'b1, 5'd6, 32'h600, 1'b1, 5'd13, 32'hD0D0);
        tick();
        drive(1'b1, 5'd6, 32'h601, 1'b0, 5'd0, 32'h0);
        tick();
        drive(1'b1, 5'd6, 32'h602, 1'b0, 5'd0, 32'h0);
        tick();
        rst_n = 1'b0;
        drive(1'b1, 5'd6, 32'h603, 1'b1, 5'd8, 32'h8);
        port("rst_held", 1'b0, 5'd0, 32'h0, 1'b0);
        check("rst_held.mdu_ready", 32'(mdu_ready), 32'h0);
        check("rst_held.mdu_pend", 32'(mdu_pend), 32'h0);
        check("rst_held.mdu_pend_rd", 32'(mdu_pend_rd), 32'h0);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("post_rst.mdu_pend", 32'(mdu_pend), 32'h0);
        check("post_rst.mdu_ready", 32'(mdu_ready), 32'h1);
        port("post_rst", 1'b0, 5'd0, 32'h0, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        port("post_rst2", 1'b0, 5'd0, 32'h0, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
